// File: rtl/output_serializer_n.sv
// MSB-first word serializer with a one-word skid register and a zero-tail frame terminator.
// Optional parity pin is enabled with `define OUTPUT_PARITY_EN.
module output_serializer_n #(
    parameter int DATA_W   = 4,
    parameter int LANES    = 2,
    parameter int TAIL_LEN = 3,
    parameter int CNT_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              mode,
    input  logic              validIn,
    output logic              ready,
    output logic [LANES-1:0]  out,
    output logic              validOut,
    output logic              lastOut,
    output logic [CNT_W-1:0]  wordCount
`ifdef OUTPUT_PARITY_EN
    ,
    output logic              parOut
`endif
);

    localparam int SHIFTS   = DATA_W / LANES;
    localparam int TAIL_CYC = TAIL_LEN * SHIFTS;
    localparam int CNT_MAX  = (TAIL_CYC > SHIFTS) ? TAIL_CYC : SHIFTS;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   wordCount_q, wordCount_d;
    logic               holdValid_q, holdValid_d;
    logic [DATA_W-1:0]  holdData_q, holdData_d;
    logic               holdMode_q, holdMode_d;

    logic               shiftFinal;
    logic               tailFinal;
    logic               accept;
    logic               canLoad;
    logic               loadValid;
    logic               loadMode;
    logic [DATA_W-1:0]  loadData;

    assign shiftFinal = (state_q == SHIFT) && (cnt_q == CW'(SHIFTS - 1));
    assign tailFinal  = (state_q == TAIL)  && (cnt_q == CW'(TAIL_CYC - 1));
    assign ready      = !holdValid_q && (state_q != TAIL);
    assign accept     = validIn && ready;
    assign canLoad    = (state_q == IDLE) || shiftFinal;

    // The skid word always has priority over a fresh input when the shifter frees up.
    assign loadValid  = canLoad && (holdValid_q || accept);
    assign loadMode   = holdValid_q ? holdMode_q : mode;
    assign loadData   = holdValid_q ? holdData_q : in;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q << LANES;
        cnt_d       = cnt_q + 1'b1;
        wordCount_d = wordCount_q;
        holdValid_d = holdValid_q;
        holdData_d  = holdData_q;
        holdMode_d  = holdMode_q;

        if (accept && !canLoad) begin
            holdValid_d = 1'b1;
            holdData_d  = in;
            holdMode_d  = mode;
        end else if (loadValid && holdValid_q) begin
            holdValid_d = 1'b0;
        end

        if (state_q == IDLE) begin
            cnt_d = '0;
        end

        if (loadValid) begin
            cnt_d = '0;
            if (loadMode) begin
                state_d = TAIL;
                shift_d = '0;
            end else begin
                state_d     = SHIFT;
                shift_d     = loadData;
                wordCount_d = wordCount_q + 1'b1;
            end
        end else if (shiftFinal) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
        end else if (tailFinal) begin
            state_d     = IDLE;
            shift_d     = '0;
            cnt_d       = '0;
            wordCount_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wordCount_q <= '0;
            holdValid_q <= 1'b0;
            holdData_q  <= '0;
            holdMode_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wordCount_q <= wordCount_d;
            holdValid_q <= holdValid_d;
            holdData_q  <= holdData_d;
            holdMode_q  <= holdMode_d;
        end
    end

    assign validOut  = (state_q != IDLE);
    assign out       = validOut ? shift_q[DATA_W-1 -: LANES] : '0;
    assign lastOut   = tailFinal;
    assign wordCount = wordCount_q;

`ifdef OUTPUT_PARITY_EN
    assign parOut = validOut & (^out);
`else
    // Parity pin is not present in this build.
`endif

endmodule

// File: tb/tb_output_serializer_n.sv
// Directed bench for output_serializer_n at default parameters; parity checks under OUTPUT_PARITY_EN.
module tb_output_serializer_n;

    logic        clk;
    logic        reset;
    logic [3:0]  in;
    logic        mode;
    logic        validIn;
    logic        ready;
    logic [1:0]  out;
    logic        validOut;
    logic        lastOut;
    logic [11:0] wordCount;
`ifdef OUTPUT_PARITY_EN
    logic        parOut;
`endif

    int errors = 0;
    int checks = 0;

    output_serializer_n dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .mode      (mode),
        .validIn   (validIn),
        .ready     (ready),
        .out       (out),
        .validOut  (validOut),
        .lastOut   (lastOut),
        .wordCount (wordCount)
`ifdef OUTPUT_PARITY_EN
        ,
        .parOut    (parOut)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic m, input logic [3:0] d);
        validIn = v;
        mode    = m;
        in      = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".out"}, 32'(out), 32'd0);
        checkOutput({tag, ".validOut"}, 32'(validOut), 32'd0);
        checkOutput({tag, ".lastOut"}, 32'(lastOut), 32'd0);
        checkOutput({tag, ".wordCount"}, 32'(wordCount), 32'd0);
        checkOutput({tag, ".ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int          accepts;
        int          bubbleErrs;
        int          dataErrs;
        int          readyErrs;
        int          countErrs;
        int          w;
        int          grp;
        logic [3:0]  wv;
        logic [1:0]  expOut;
        logic [11:0] expCount;
        logic        acceptNow;

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        checkResetValues("reset");

        // Single word 0xB from idle: groups 10 then 11.
        applyStimulus(1'b1, 1'b0, 4'hB);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("wordB.g0.out", 32'(out), 32'h2);
        checkOutput("wordB.g0.validOut", 32'(validOut), 32'd1);
`ifdef OUTPUT_PARITY_EN
        checkOutput("wordB.g0.parOut", 32'(parOut), 32'd1);
`endif
        nextCycle();
        checkOutput("wordB.g1.out", 32'(out), 32'h3);
        checkOutput("wordB.g1.validOut", 32'(validOut), 32'd1);
`ifdef OUTPUT_PARITY_EN
        checkOutput("wordB.g1.parOut", 32'(parOut), 32'd0);
`endif
        nextCycle();
        checkOutput("wordB.after.validOut", 32'(validOut), 32'd0);
        checkOutput("wordB.after.out", 32'(out), 32'd0);
        checkOutput("wordB.after.wordCount", 32'(wordCount), 32'd1);
`ifdef OUTPUT_PARITY_EN
        checkOutput("wordB.after.parOut", 32'(parOut), 32'd0);
`endif

        // Word 0x6, a three-cycle source stall, then word 0x9.
        applyStimulus(1'b1, 1'b0, 4'h6);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("word6.g0.out", 32'(out), 32'h1);
        nextCycle();
        checkOutput("word6.g1.out", 32'(out), 32'h2);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("stall%0d.validOut", i), 32'(validOut), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 4'h9);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("word9.g0.out", 32'(out), 32'h2);
        checkOutput("word9.g0.validOut", 32'(validOut), 32'd1);
        checkOutput("word9.wordCount", 32'(wordCount), 32'd3);
        nextCycle();
        checkOutput("word9.g1.out", 32'(out), 32'h1);
        nextCycle();

        // Word 0x5 followed by a termination request that lands in the skid register.
        applyStimulus(1'b1, 1'b0, 4'h5);
        nextCycle();
        checkOutput("word5.g0.out", 32'(out), 32'h1);
        checkOutput("word5.wordCount", 32'(wordCount), 32'd4);
        applyStimulus(1'b1, 1'b1, 4'hF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("word5.g1.out", 32'(out), 32'h1);
        checkOutput("word5.g1.ready", 32'(ready), 32'd0);
        nextCycle();
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("tail%0d.out", i), 32'(out), 32'd0);
            checkOutput($sformatf("tail%0d.validOut", i), 32'(validOut), 32'd1);
            checkOutput($sformatf("tail%0d.ready", i), 32'(ready), 32'd0);
            checkOutput($sformatf("tail%0d.lastOut", i), 32'(lastOut), (i == 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("tail%0d.wordCount", i), 32'(wordCount), 32'd4);
            nextCycle();
        end
        checkOutput("postTail.wordCount", 32'(wordCount), 32'd0);
        checkOutput("postTail.validOut", 32'(validOut), 32'd0);
        checkOutput("postTail.lastOut", 32'(lastOut), 32'd0);
        checkOutput("postTail.ready", 32'(ready), 32'd1);

        // Reset asserted on the second tail cycle of a frame.
        applyStimulus(1'b1, 1'b0, 4'hA);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 4'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'h0);
        nextCycle();
        checkOutput("rstTail.t0.validOut", 32'(validOut), 32'd1);
        checkOutput("rstTail.t0.wordCount", 32'(wordCount), 32'd1);
        nextCycle();
        reset = 1'b0;
        checkOutput("rstTail.t1.validOut", 32'(validOut), 32'd1);
        checkOutput("rstTail.t1.lastOut", 32'(lastOut), 32'd0);
        nextCycle();
        reset = 1'b1;
        checkResetValues("rstTail.after");
        nextCycle();
        checkOutput("rstTail.idle.validOut", 32'(validOut), 32'd0);
        checkOutput("rstTail.idle.lastOut", 32'(lastOut), 32'd0);

        // Sustained stream of 4096 words with validIn held high.
        accepts    = 0;
        bubbleErrs = 0;
        dataErrs   = 0;
        readyErrs  = 0;
        countErrs  = 0;
        applyStimulus(1'b1, 1'b0, 4'h0);
        for (int cyc = 0; cyc <= 8192; cyc++) begin
            if (cyc >= 1) begin
                w        = (cyc - 1) / 2;
                grp      = (cyc - 1) % 2;
                wv       = w[3:0];
                expOut   = (grp == 0) ? wv[3:2] : wv[1:0];
                expCount = 12'(w + 1);
                if (validOut !== 1'b1) bubbleErrs++;
                if (out !== expOut) dataErrs++;
                if (wordCount !== expCount) countErrs++;
                if (cyc <= 8190 && ready !== cyc[0]) readyErrs++;
            end else if (ready !== 1'b1) begin
                readyErrs++;
            end
            acceptNow = validIn && ready;
            nextCycle();
            if (acceptNow) begin
                accepts++;
                in = in + 4'd1;
            end
            validIn = (accepts < 4096);
        end
        checkOutput("stream.bubbles", 32'(bubbleErrs), 32'd0);
        checkOutput("stream.dataErrs", 32'(dataErrs), 32'd0);
        checkOutput("stream.readyErrs", 32'(readyErrs), 32'd0);
        checkOutput("stream.countErrs", 32'(countErrs), 32'd0);
        checkOutput("stream.accepts", 32'(accepts), 32'd4096);
        checkOutput("stream.end.validOut", 32'(validOut), 32'd0);
        checkOutput("stream.end.wordCount", 32'(wordCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
